// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: operation codes and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/iterative_shift_unit_if.sv
// Request/response handshake bundle between the core and the iterative shift unit.
interface iterative_shift_unit_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
);

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op;
    logic [XLEN-1:0]    operand;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    result;
    logic               busy;

    modport master (
        output in_valid, op, operand, shamt, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, operand, shamt, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/shift_step.sv
// Combinational single step: shifts data by 0..STEP bits for the given op.
// Rotate is only built when SHIFT_ROTATE_EN is defined; otherwise op 11 acts as SRL.
module shift_step
    import shift_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned STEP  = 4,
    localparam int unsigned AMT_W = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0]  data,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic [XLEN-1:0]  result
);

    always_comb begin
        result = data;
        case (op)
            OP_SLL: result = data << amt;
            // The work register keeps the original sign bit, so every step refills with it.
            OP_SRA: result = $unsigned($signed(data) >>> amt);
`ifdef SHIFT_ROTATE_EN
            OP_ROR: result = (data >> amt) | (data << (XLEN - 32'(amt)));
`endif
            default: result = data >> amt;
        endcase
    end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit shifting at most STEP bits per cycle behind a valid/ready bus.
// Define SHIFT_ROTATE_EN to add rotate-right on op 11.
module iterative_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    iterative_shift_unit_if.slave bus
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned AMT_W   = $clog2(STEP + 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [XLEN-1:0]    work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0]   step_amt;
    logic [XLEN-1:0]    step_out;

    always_comb begin
        if (32'(rem_q) < STEP) begin
            step_amt = AMT_W'(rem_q);
        end else begin
            step_amt = AMT_W'(STEP);
        end
    end

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .data   (work_q),
        .op     (op_q),
        .amt    (step_amt),
        .result (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    work_d  = bus.operand;
                    rem_d   = bus.shamt;
                    state_d = (bus.shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - SHAMT_W'(step_amt);
                if (rem_q == SHAMT_W'(step_amt)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            work_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
        end
    end

    // in_ready looks at reset directly so the core never sees a ready unit during reset.
    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == SHIFT) || (state_q == DONE);
    assign bus.result    = work_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: directed vectors, random traffic, backpressure,
// mid-operation reset and back-to-back handshakes against an arithmetic reference model.
module tb_iterative_shift_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned STEP = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    iterative_shift_unit_if #(.XLEN(XLEN)) bus ();

    iterative_shift_unit #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input int s);
        logic [31:0] r;
        case (op)
            2'd0: r = a << s;
            2'd1: r = a >> s;
            2'd2: begin
                r = a >> s;
                if (a[31] && s != 0) r = r | ~(32'hFFFF_FFFF >> s);
            end
            default: begin
`ifdef SHIFT_ROTATE_EN
                r = a;
                for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
`else
                r = a >> s;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic int lat_model(input int s);
        return (s + STEP - 1) / STEP;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request while the unit is idle; returns just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input int s);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_before_issue: got %b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.operand  = a;
        bus.shamt    = 5'(s);
        cycle();
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.operand  = $urandom;
        bus.shamt    = 5'($urandom);
    endtask

    // Counts edges after accept until out_valid; flags busy drops and expired budgets.
    task automatic wait_done(output logic [31:0] r, output int lat, output bit busy_ok,
                             output bit timed_out);
        lat = 0;
        busy_ok = 1'b1;
        timed_out = 1'b0;
        while (bus.out_valid !== 1'b1) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat >= 64) begin
                timed_out = 1'b1;
                break;
            end
            cycle();
            lat++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        r = bus.result;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000 || bus.result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b res=%h want 0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b busy=%b want 1/0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5] = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
        logic [31:0] opa [5] = '{32'hC000_0034, 32'h1, 32'h8000_0000, 32'd52, 32'h1};
        int          sh  [5] = '{2, 31, 31, 0, 4};
        logic [31:0] exp [5];
        logic [31:0] r;
        int lat;
        bit busy_ok, to;
        exp[0] = 32'hF000_000D;
        exp[1] = 32'h8000_0000;
        exp[2] = 32'h0000_0001;
        exp[3] = 32'd52;
`ifdef SHIFT_ROTATE_EN
        exp[4] = 32'h1000_0000;
`else
        exp[4] = 32'h0000_0000;
`endif
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], opa[i], sh[i]);
            wait_done(r, lat, busy_ok, to);
            n_cmp++;
            if (to || r !== exp[i] || lat !== lat_model(sh[i]) || !busy_ok) begin
                n_err++;
                $display("FAIL directed_%0d: got res=%h lat=%0d busy_ok=%b to=%b want res=%h lat=%0d",
                         i, r, lat, busy_ok, to, exp[i], lat_model(sh[i]));
            end
            bus.out_ready = 1'b1;
            cycle();
            bus.out_ready = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL directed_drain_%0d: got vld=%b rdy=%b want 0/1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, exp, r;
        int s, lat, gap;
        bit busy_ok, to;
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            s   = $urandom_range(0, 31);
            exp = model(op, a, s);
            issue(op, a, s);
            wait_done(r, lat, busy_ok, to);
            n_cmp++;
            if (to || r !== exp || lat !== lat_model(s) || !busy_ok) begin
                n_err++;
                $display("FAIL random_%0d op=%0d a=%h s=%0d: got res=%h lat=%0d busy_ok=%b want res=%h lat=%0d",
                         i, op, a, s, r, lat, busy_ok, exp, lat_model(s));
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cycle();
            n_cmp++;
            if (bus.result !== exp || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL random_hold_%0d: got res=%h vld=%b want res=%h vld=1",
                         i, bus.result, bus.out_valid, exp);
            end
            bus.out_ready = 1'b1;
            cycle();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp, r;
        int lat;
        bit busy_ok, to;
        exp = model(2'd2, 32'h8765_4321, 13);
        issue(2'd2, 32'h8765_4321, 13);
        wait_done(r, lat, busy_ok, to);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.operand  = $urandom;
            cycle();
            n_cmp++;
            if (bus.result !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_%0d: got res=%h vld=%b rdy=%b want res=%h vld=1 rdy=0",
                         k, bus.result, bus.out_valid, bus.in_ready, exp);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_b, r;
        int lat;
        bit busy_ok, to;
        exp_b = model(2'd0, 32'h0000_ABCD, 9);
        issue(2'd1, 32'hFFFF_0000, 5);
        wait_done(r, lat, busy_ok, to);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 2'd0;
        bus.operand   = 32'h0000_ABCD;
        bus.shamt     = 5'd9;
        cycle();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_bypass: got vld=%b rdy=%b busy=%b want 0/1/0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        cycle();
        bus.in_valid = 1'b0;
        wait_done(r, lat, busy_ok, to);
        n_cmp++;
        if (to || r !== exp_b || lat !== lat_model(9) || !busy_ok) begin
            n_err++;
            $display("FAIL b2b_second: got res=%h lat=%0d busy_ok=%b want res=%h lat=%0d",
                     r, lat, busy_ok, exp_b, lat_model(9));
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int lat;
        bit busy_ok, to, seen;
        issue(2'd0, 32'h1, 31);
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000 || bus.result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got rdy=%b vld=%b busy=%b res=%h want 0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
        cycle();
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_mid_discard: got stray output/busy after reset, want none");
        end
        issue(2'd1, 32'h8000_0000, 31);
        wait_done(r, lat, busy_ok, to);
        n_cmp++;
        if (to || r !== 32'h1 || lat !== 8) begin
            n_err++;
            $display("FAIL reset_mid_recover: got res=%h lat=%0d want res=00000001 lat=8", r, lat);
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'd0;
        bus.operand   = '0;
        bus.shamt     = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
